// File: rtl/scrambler.sv
// Additive scrambler for an AXI-Stream data path, polynomial x^7 + x^4 + 1
// (the IEEE 802.11 OFDM scrambler). Each accepted beat is scrambled WIDTH
// bits at a time in one cycle. Data bit 0 is the earliest bit in time.
// The result is presented through a single output register stage.
// The keystream restarts from SEED after every beat flagged with tlast.
// Scrambling is self-inverse, so a second instance with the same SEED
// descrambles the stream.
// SEED must be non-zero: an all-zero state never leaves zero and would
// produce no keystream at all.
// The reset port keeps its AXI name, aresetn, but it is active-high
// (1 = reset). It is expected to be released synchronously to aclk.
module scrambler #(
    parameter int         WIDTH = 8,
    parameter logic [6:0] SEED  = 7'b1111111
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [WIDTH-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast
);

    logic [6:0]       lfsr_state;
    logic [6:0]       lfsr_next;
    logic [WIDTH-1:0] scrambled;
    logic             in_accept;

    // Accept new input whenever the output register is empty or being drained this cycle; never during reset
    always_comb begin
        s_axis_tready = (~m_axis_tvalid | m_axis_tready) & ~aresetn;
        in_accept     = s_axis_tvalid & s_axis_tready;
    end

    // Step the LFSR once per data bit, earliest bit first, to get this beat's keystream and the state after it
    always_comb begin
        logic [6:0] s;
        logic       fb;
        s         = lfsr_state;
        fb        = 1'b0;
        scrambled = '0;
        for (int i = 0; i < WIDTH; i++) begin
            fb           = s[6] ^ s[3];
            scrambled[i] = s_axis_tdata[i] ^ fb;
            s            = {s[5:0], fb};
        end
        lfsr_next = s;
    end

    // Advance the scrambler state only on an accepted beat; a frame end rewinds it to SEED for the next frame
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            lfsr_state <= SEED;
        end else if (in_accept) begin
            lfsr_state <= s_axis_tlast ? SEED : lfsr_next;
        end
    end

    // Output register: load on accept, clear valid when drained with nothing new, hold while stalled
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else if (in_accept) begin
            m_axis_tdata  <= scrambled;
            m_axis_tlast  <= s_axis_tlast;
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_scrambler.sv
// Directed testbench for scrambler. The 8-bit instance covers the reset
// state, the first-beat keystream, output stalls, mid-stream reset and
// frame restart on tlast. The 24-bit pair, a scrambler feeding a
// descrambler, covers keystream periodicity and round-trip recovery.
module tb_scrambler;

    localparam logic [6:0] TB_SEED = 7'b1011101;

    logic aclk = 1'b0;
    logic aresetn;

    logic [7:0]  s8_tdata;
    logic        s8_tvalid;
    logic        s8_tready;
    logic        s8_tlast;
    logic [7:0]  m8_tdata;
    logic        m8_tvalid;
    logic        m8_tready;
    logic        m8_tlast;

    logic [23:0] sa_tdata;
    logic        sa_tvalid;
    logic        sa_tready;
    logic        sa_tlast;
    logic [23:0] ma_tdata;
    logic        ma_tvalid;
    logic        ma_tlast;
    logic        sb_tready;
    logic [23:0] mb_tdata;
    logic        mb_tvalid;
    logic        mb_tready;
    logic        mb_tlast;

    int checkCount = 0;
    int errorCount = 0;

    scrambler #(.WIDTH(8), .SEED(TB_SEED)) dut8 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s8_tdata), .s_axis_tvalid(s8_tvalid),
        .s_axis_tready(s8_tready), .s_axis_tlast(s8_tlast),
        .m_axis_tdata(m8_tdata), .m_axis_tvalid(m8_tvalid),
        .m_axis_tready(m8_tready), .m_axis_tlast(m8_tlast)
    );

    scrambler #(.WIDTH(24), .SEED(TB_SEED)) dut_scr (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(sa_tdata), .s_axis_tvalid(sa_tvalid),
        .s_axis_tready(sa_tready), .s_axis_tlast(sa_tlast),
        .m_axis_tdata(ma_tdata), .m_axis_tvalid(ma_tvalid),
        .m_axis_tready(sb_tready), .m_axis_tlast(ma_tlast)
    );

    scrambler #(.WIDTH(24), .SEED(TB_SEED)) dut_descr (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(ma_tdata), .s_axis_tvalid(ma_tvalid),
        .s_axis_tready(sb_tready), .s_axis_tlast(ma_tlast),
        .m_axis_tdata(mb_tdata), .m_axis_tvalid(mb_tvalid),
        .m_axis_tready(mb_tready), .m_axis_tlast(mb_tlast)
    );

    always #5 aclk = ~aclk;

    // Bit-serial reference keystream: fb = s[6]^s[3], shifted into s[0]
    function automatic logic [191:0] refKeystream(input logic [6:0] seed);
        logic [191:0] ks;
        logic [6:0]   s;
        ks = '0;
        s  = seed;
        for (int k = 0; k < 192; k++) begin
            ks[k] = s[6] ^ s[3];
            s     = {s[5:0], ks[k]};
        end
        return ks;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic valid, input logic last);
        s8_tdata  = data;
        s8_tvalid = valid;
        s8_tlast  = last;
    endtask

    logic [191:0] ks_ref;
    logic [143:0] ks_seen;
    logic [23:0]  vec  [8];
    logic         vlast[8];

    initial begin
        aresetn   = 1'b1;
        s8_tdata  = '0; s8_tvalid = 1'b0; s8_tlast = 1'b0; m8_tready = 1'b0;
        sa_tdata  = '0; sa_tvalid = 1'b0; sa_tlast = 1'b0; mb_tready = 1'b1;
        ks_ref    = refKeystream(TB_SEED);
        ks_seen   = '0;
        vec   = '{24'h123456, 24'hABCDEF, 24'hFFFFFF, 24'h000001,
                  24'h800000, 24'h5A5AA5, 24'hC3C3C3, 24'h0F0F0F};
        vlast = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset state
        repeat (2) @(negedge aclk);
        checkOutput("reset_m_tvalid", 64'(m8_tvalid), 64'd0);
        checkOutput("reset_m_tdata",  64'(m8_tdata),  64'd0);
        checkOutput("reset_m_tlast",  64'(m8_tlast),  64'd0);
        checkOutput("reset_s_tready", 64'(s8_tready), 64'd0);
        checkOutput("reset_s_tready_24", 64'(sa_tready), 64'd0);

        // First beat after reset: zero data exposes keystream bits 0..7
        aresetn   = 1'b0;
        m8_tready = 1'b1;
        applyStimulus(8'h00, 1'b1, 1'b0);
        #1 checkOutput("s_tready_after_release", 64'(s8_tready), 64'd1);
        @(negedge aclk);
        checkOutput("first_valid", 64'(m8_tvalid), 64'd1);
        checkOutput("first_data",  64'(m8_tdata),  64'h36);
        applyStimulus(8'h00, 1'b0, 1'b0);
        @(negedge aclk);
        checkOutput("drain_valid_low", 64'(m8_tvalid), 64'd0);

        // Stall: beat 2 (keystream bits 8..15) held, beat 3 waits
        m8_tready = 1'b0;
        applyStimulus(8'h00, 1'b1, 1'b0);
        @(negedge aclk);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("stall_s_tready_%0d", i), 64'(s8_tready), 64'd0);
            checkOutput($sformatf("stall_data_%0d", i),     64'(m8_tdata),  64'h98);
            checkOutput($sformatf("stall_valid_%0d", i),    64'(m8_tvalid), 64'd1);
            @(negedge aclk);
        end
        m8_tready = 1'b1;
        @(negedge aclk);
        checkOutput("resume_valid", 64'(m8_tvalid), 64'd1);
        checkOutput("resume_data",  64'(m8_tdata),  64'h95);
        applyStimulus(8'h00, 1'b0, 1'b0);
        @(negedge aclk);
        checkOutput("resume_drain", 64'(m8_tvalid), 64'd0);

        // Mid-frame reset while an output beat is held
        m8_tready = 1'b0;
        applyStimulus(8'h00, 1'b1, 1'b0);
        @(negedge aclk);
        checkOutput("pre_reset_valid", 64'(m8_tvalid), 64'd1);
        applyStimulus(8'h00, 1'b0, 1'b0);
        #2 aresetn = 1'b1;
        #1;
        checkOutput("async_reset_valid",  64'(m8_tvalid), 64'd0);
        checkOutput("async_reset_data",   64'(m8_tdata),  64'd0);
        checkOutput("async_reset_tready", 64'(s8_tready), 64'd0);
        @(negedge aclk);
        aresetn   = 1'b0;
        m8_tready = 1'b1;
        applyStimulus(8'h00, 1'b1, 1'b0);
        @(negedge aclk);
        checkOutput("post_reset_data", 64'(m8_tdata), 64'h36);

        // Frame end: 0xA5 with tlast at keystream bits 8..15, then SEED restart
        applyStimulus(8'hA5, 1'b1, 1'b1);
        @(negedge aclk);
        checkOutput("tlast_beat_data", 64'(m8_tdata), 64'h3D);
        checkOutput("tlast_beat_last", 64'(m8_tlast), 64'd1);
        applyStimulus(8'h00, 1'b1, 1'b0);
        @(negedge aclk);
        checkOutput("new_frame_data", 64'(m8_tdata), 64'h36);
        checkOutput("new_frame_last", 64'(m8_tlast), 64'd0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        @(negedge aclk);

        // Six zero beats back-to-back on the 24-bit pair: 144 keystream bits
        for (int i = 0; i <= 6; i++) begin
            if (i > 0) begin
                checkOutput($sformatf("ks_valid_%0d", i - 1), 64'(ma_tvalid), 64'd1);
                ks_seen[(i - 1) * 24 +: 24] = ma_tdata;
            end
            sa_tdata  = 24'h0;
            sa_tvalid = (i < 6);
            sa_tlast  = 1'b0;
            @(negedge aclk);
        end
        checkOutput("ks24_first_low_byte", 64'(ks_seen[7:0]), 64'h36);
        checkOutput("ks24_all_bits", 64'(ks_seen[63:0]), ks_ref[63:0]);
        checkOutput("ks24_all_bits_hi", 64'(ks_seen[143:64]), 64'(ks_ref[143:64]));
        for (int k = 0; k <= 16; k++) begin
            checkOutput($sformatf("period_bit_%0d", k), 64'(ks_seen[k]), 64'(ks_seen[k + 127]));
        end
        repeat (2) @(negedge aclk);

        // Round trip: scrambler then descrambler returns the original beats
        for (int i = 0; i < 10; i++) begin
            if (i >= 2) begin
                checkOutput($sformatf("roundtrip_valid_%0d", i - 2), 64'(mb_tvalid), 64'd1);
                checkOutput($sformatf("roundtrip_data_%0d", i - 2),  64'(mb_tdata),  64'(vec[i - 2]));
                checkOutput($sformatf("roundtrip_last_%0d", i - 2),  64'(mb_tlast),  64'(vlast[i - 2]));
            end
            if (i < 8) begin
                sa_tdata  = vec[i];
                sa_tvalid = 1'b1;
                sa_tlast  = vlast[i];
            end else begin
                sa_tdata  = 24'h0;
                sa_tvalid = 1'b0;
                sa_tlast  = 1'b0;
            end
            @(negedge aclk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/scrambler.md
SCRAMBLER -- requirements
Module: scrambler

Interface
REQ-001 Parameter WIDTH, default 8, meaning: data bits per AXI-Stream beat; the block SHALL support any WIDTH from 1 to 64.
REQ-002 Parameter SEED, default 7'b1111111, meaning: initial 7-bit scrambler state; all-zero SEED SHALL be treated as unsupported.
REQ-003 aclk  input  1  single clock; all logic SHALL be synchronous to its rising edge.
REQ-004 aresetn  input  1  reset, asynchronous assertion, active-high (1 = reset), deassertion synchronous to aclk.
REQ-005 s_axis_tdata  input  WIDTH  unscrambled data; bit 0 is the earliest bit in time.
REQ-006 s_axis_tvalid  input  1  input beat valid.
REQ-007 s_axis_tready  output  1  input beat accepted when high together with s_axis_tvalid.
REQ-008 s_axis_tlast  input  1  last beat of frame.
REQ-009 m_axis_tdata  output  WIDTH  scrambled data, same bit ordering as input.
REQ-010 m_axis_tvalid  output  1  output beat valid.
REQ-011 m_axis_tready  input  1  downstream ready.
REQ-012 m_axis_tlast  output  1  tlast of the beat in m_axis_tdata.

Function
REQ-013 Polynomial SHALL be x^7 + x^4 + 1 (IEEE 802.11 OFDM scrambler); state s[6:0], s[6]=x7, s[0]=x1.
REQ-014 Per bit, in order from bit 0 to bit WIDTH-1: fb = s[6] XOR s[3]; out_bit = in_bit XOR fb; s <= {s[5:0], fb}.
REQ-015 One accepted beat SHALL advance the state by exactly WIDTH bit steps, computed combinationally in one cycle.
REQ-016 The state SHALL advance only on input acceptance (s_axis_tvalid & s_axis_tready); stalls SHALL NOT advance it.
REQ-017 After accepting a beat with s_axis_tlast=1, the state SHALL reload SEED so each frame starts from SEED.
REQ-018 Output SHALL be a single register stage: an accepted beat SHALL appear on m_axis_tdata/m_axis_tlast with m_axis_tvalid=1 on the next rising edge (latency 1 cycle).
REQ-019 s_axis_tready SHALL equal (NOT m_axis_tvalid) OR m_axis_tready.
REQ-020 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata, m_axis_tlast and m_axis_tvalid SHALL hold stable.
REQ-021 On an edge with output accepted and no new input accepted, m_axis_tvalid SHALL go to 0; with both accepted simultaneously, the new beat SHALL replace the old one without a bubble.
REQ-022 The generated keystream SHALL have period 127 bits (keystream bit k equals bit k+127) when no tlast is asserted.
REQ-023 Applying the block twice with the same SEED SHALL return the original data (self-inverse descrambling).

Reset
REQ-024 While aresetn=1: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, s_axis_tready=0, state=SEED.
REQ-025 Reset asserted mid-stream SHALL discard any held output beat and reload SEED immediately (asynchronously).
REQ-026 The first beat accepted after reset release SHALL be scrambled with the keystream starting at bit 0 from SEED.

Verification
REQ-027 SEED=1011101, WIDTH=8, reset, input 0x00 with m_tready=1 -> m_tdata=0x36 (keystream bits 0..7 = 0,1,1,0,1,1,0,0) one cycle after acceptance.
REQ-028 SEED=1011101, WIDTH=24, six zero beats back-to-back -> 144 keystream bits; bit k == bit k+127 for k=0..16; first beat low byte 0x36.
REQ-029 Random 24-bit beats through scrambler, outputs fed to a second instance with same SEED -> second output equals original input bit-exact.
REQ-030 Hold m_tready=0 with m_tvalid=1 for 5 cycles while s_tvalid=1 -> s_tready=0, output stable, state not advanced; releasing m_tready resumes with correct continuation of keystream.
REQ-031 Beat with s_tlast=1 followed by zero beat -> m_tlast=1 on first output, second output equals first-beat keystream from SEED (0x36 in low byte for SEED=1011101).
REQ-032 Assert aresetn for one cycle mid-frame while m_tvalid=1 -> m_tvalid=0 immediately; next zero beat after release yields keystream from SEED.
